// File: rtl/mem_responder.sv
// mem_responder: multi-cycle 16-bit data-memory responder with stall/done.
// Optional misaligned-address rejection: MEM_RESPONDER_ALIGN_CHK_EN.
module mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_wdata;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_bad;
  logic [15:0]           r_dout;
  logic                  r_stall;
  logic                  r_done;
  logic                  r_err;
  logic [15:0]           r_mem [DEPTH];

  logic w_accept;
  logic w_exec;
  logic w_we;
  logic w_re;
  logic w_misalign;
  logic w_bad;
  logic w_unused_addr;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
  assign w_misalign = addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Upper address bits alias away; bit 0 only matters with the align check.
  assign w_unused_addr = ^{addr[15:DEPTH_LOG2+1], addr[0]};

  assign w_accept = (r_state == IDLE) && (rd || wr);
  assign w_bad    = (rd && wr) || w_misalign;
  assign w_exec   = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_we     = w_exec && r_wr && !r_bad && !rst;
  assign w_re     = w_exec && r_rd && !r_bad;

  // Next-state decode: DONE always returns to IDLE, ignoring inputs.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (rd || wr) w_next = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stall <= (w_next == BUSY);
      r_done  <= (w_next == DONE);
      r_err   <= (w_next == DONE) && r_bad;
    end
  end

  // Request capture at accept, latency countdown while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= 4'(LATENCY - 1);
      r_idx   <= addr[DEPTH_LOG2:1];
      r_wdata <= data_in;
      r_rd    <= rd;
      r_wr    <= wr;
      r_bad   <= w_bad;
    end else if (r_state == BUSY && r_cnt != 4'd0) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Load result: updated only by a successful load, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= 16'h0000;
    end else if (w_re) begin
      r_dout <= r_mem[r_idx];
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign data_out = r_dout;
  assign stall    = r_stall;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=4).
// Expected done responses are queued by stimulus and checked by a monitor.
module tb_mem_responder;

  localparam int LAT = 4;

  typedef struct {
    logic [15:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  int   tests;
  int   fails;
  int   scnt;
  exp_t q[$];

  mem_responder #(
    .LATENCY    (LAT),
    .DEPTH_LOG2 (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr),
    .data_out (data_out),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count stall cycles and score each done pulse.
  initial begin
    scnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0;
      end else begin
        if (stall) scnt++;
        if (done) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_done: got done with empty queue, expected none");
          end else begin
            exp_t e;
            e = q.pop_front();
            check({e.name, "_stall"}, 16'(scnt), 16'(LAT));
            check({e.name, "_err"}, {15'd0, err}, {15'd0, e.err});
            check({e.name, "_data"}, data_out, e.data);
          end
          scnt = 0;
        end
      end
    end
  end

  // One access: present request, wait bounded for done, return to idle.
  task automatic access(input string name, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] edata, input logic eerr,
                        input bit noise);
    exp_t e;
    bit   seen;
    e.data = edata;
    e.err  = eerr;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    rd = r; wr = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (noise) begin
        rd = 1'($urandom); wr = 1'($urandom);
        addr = 16'($urandom); data_in = 16'($urandom);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done", name);
    end
    if (noise) begin
      rd = 1'($urandom); wr = 1'($urandom);
      addr = 16'($urandom); data_in = 16'($urandom);
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      check({name, "_no_extra_accept"}, {15'd0, stall}, 16'd0);
    end
  endtask

  logic [15:0] odd_exp_err;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    addr = 16'h0000; data_in = 16'h0000;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    odd_exp_err = 16'd1;
`else
    odd_exp_err = 16'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_data", data_out, 16'h0000);
    rst = 1'b0;

    access("wr10", 0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 0);
    access("rd10", 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
    access("rdwr10", 1, 1, 16'h0010, 16'h0123, 16'hBEEF, 1, 0);
    access("rd10b", 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0);
    access("rd11", 1, 0, 16'h0011, 16'h0000, 16'hBEEF,
           odd_exp_err[0], 0);
    access("wr20n", 0, 1, 16'h0020, 16'h1234, 16'hBEEF, 0, 1);
    access("rd20", 1, 0, 16'h0020, 16'h0000, 16'h1234, 0, 0);
    access("wr30", 0, 1, 16'h0030, 16'h5555, 16'h1234, 0, 0);

    // Store aborted by reset in its second busy cycle.
    @(negedge clk);
    wr = 1'b1; addr = 16'h0030; data_in = 16'hAAAA;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_stall", {15'd0, stall}, 16'd0);
    check("rstmid_done", {15'd0, done}, 16'd0);
    check("rstmid_err", {15'd0, err}, 16'd0);
    check("rstmid_data", data_out, 16'h0000);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid_idle", {15'd0, stall}, 16'd0);

    access("rd30", 1, 0, 16'h0030, 16'h0000, 16'h5555, 0, 0);
    access("wr802", 0, 1, 16'h0802, 16'h7777, 16'h5555, 0, 0);
    access("rd002", 1, 0, 16'h0002, 16'h0000, 16'h7777, 0, 0);
    access("rd803", 1, 0, 16'h0803, 16'h0000, 16'h7777,
           odd_exp_err[0], 0);

    repeat (4) @(negedge clk);
    check("queue_empty", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
